ezlogic_result_checker: RTL and testbench



---
 rtl/ezlogic_result_checker.sv | 141 ++++++++++++++
 tb/tb_ezlogic_result_checker.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ezlogic_result_checker.sv
// In-order streaming checker: compares an N-byte frame against a fixed digest, reports pass/fail and errors.
// Defining EZLOGIC_CHECKER_CAPTURE_EN adds a capture RAM of accepted bytes with a registered read port.
module ezlogic_result_checker #(
   parameter int               N        = 42,
   parameter logic [0:8*N-1]   EXPECTED = 336'h30789d5692f2fe23bb2c5d9e16406653b6cb217c952998ce17b7143788d949952680b4bce4c30a96c753,
   parameter int               TIMEOUT  = 64,
   parameter int               CW       = $clog2(N+1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          valid_in,
   input  logic [7:0]    data_in,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic          timeout,
   output logic          overflow,
   output logic [CW-1:0] byte_cnt,
   output logic [CW-1:0] mismatch_cnt,
   output logic [CW-1:0] first_mismatch
`ifdef EZLOGIC_CHECKER_CAPTURE_EN
   ,
   input  logic [CW-1:0] rd_addr,
   output logic [7:0]    rd_data
`endif
);

   localparam int IW = $clog2(TIMEOUT+1);

   if (N < 1 || TIMEOUT < 1) begin : g_bad_param
      $error("ezlogic_result_checker: N and TIMEOUT must be >= 1");
   end

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE, S_TMO} state_t;

   // Every output is a field of this register, so all outputs come straight from flops.
   typedef struct packed {
      state_t        st;
      logic          busy;
      logic          done;
      logic          pass;
      logic          timeout;
      logic          overflow;
      logic [CW-1:0] byte_cnt;
      logic [CW-1:0] mis_cnt;
      logic [CW-1:0] first_mis;
      logic [IW-1:0] idle_cnt;
   } ctx_t;

   ctx_t       q, n;
   logic       acc;
   logic       miss;
   logic [7:0] exp_b;

   always_comb begin
      exp_b = 8'h00;
      if (int'(q.byte_cnt) < N) exp_b = EXPECTED[int'(q.byte_cnt)*8 +: 8];
   end

   assign miss = acc && (data_in != exp_b);

   always_comb begin
      n   = q;
      acc = 1'b0;
      unique case (q.st)
         S_IDLE: begin
            if (valid_in) begin
               acc  = 1'b1;
               n.st = (N == 1) ? S_DONE : S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (valid_in) begin
               acc = 1'b1;
               if (q.byte_cnt == CW'(N-1)) n.st = S_DONE;
            end else if (q.idle_cnt == IW'(TIMEOUT-1)) begin
               n.st       = S_TMO;
               n.timeout  = 1'b1;
               n.idle_cnt = IW'(TIMEOUT);
            end else begin
               n.idle_cnt = q.idle_cnt + 1'b1;
            end
         end
         S_DONE: begin
            // Frame is closed: extra bytes are flagged, never compared.
            if (valid_in) n.overflow = 1'b1;
         end
         S_TMO: ;
         default: n.st = S_IDLE;
      endcase

      if (acc) begin
         n.idle_cnt = '0;
         if (q.byte_cnt < CW'(N)) n.byte_cnt = q.byte_cnt + 1'b1;
         if (miss) begin
            if (q.mis_cnt < CW'(N)) n.mis_cnt = q.mis_cnt + 1'b1;
            if (q.first_mis == CW'(N)) n.first_mis = q.byte_cnt;
         end
      end

      n.busy = (n.st == S_COLLECT);
      n.done = (n.st == S_DONE) || (n.st == S_TMO);
      n.pass = n.done && (n.mis_cnt == '0) && !n.overflow && !n.timeout;
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         q           <= '0;
         q.st        <= S_IDLE;
         q.first_mis <= CW'(N);
      end else begin
         q <= n;
      end
   end

   assign busy           = q.busy;
   assign done           = q.done;
   assign pass           = q.pass;
   assign timeout        = q.timeout;
   assign overflow       = q.overflow;
   assign byte_cnt       = q.byte_cnt;
   assign mismatch_cnt   = q.mis_cnt;
   assign first_mismatch = q.first_mis;

`ifdef EZLOGIC_CHECKER_CAPTURE_EN
   logic [N-1:0][7:0] cap_q;

   // Read returns the pre-write contents when address and write index collide.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cap_q   <= '0;
         rd_data <= 8'h00;
      end else begin
         if (acc && (q.byte_cnt < CW'(N))) cap_q[q.byte_cnt] <= data_in;
         rd_data <= (rd_addr < CW'(N)) ? cap_q[rd_addr] : 8'h00;
      end
   end
`endif

endmodule

// File: tb/tb_ezlogic_result_checker.sv
// Scoreboard bench for ezlogic_result_checker: frame-level reference model predicts every cycle's outputs.
module tb_ezlogic_result_checker;
   localparam int N       = 42;
   localparam int TIMEOUT = 64;
   localparam int CW      = $clog2(N+1);

   logic          clk = 1'b0;
   logic          rst, clear, valid_in;
   logic [7:0]    data_in;
   logic          busy, done, pass, timeout, overflow;
   logic [CW-1:0] byte_cnt, mismatch_cnt, first_mismatch;
`ifdef EZLOGIC_CHECKER_CAPTURE_EN
   logic [CW-1:0] rd_addr;
   logic [7:0]    rd_data;
`endif

   ezlogic_result_checker #(.N(N), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .clear(clear), .valid_in(valid_in), .data_in(data_in),
      .busy(busy), .done(done), .pass(pass), .timeout(timeout), .overflow(overflow),
      .byte_cnt(byte_cnt), .mismatch_cnt(mismatch_cnt), .first_mismatch(first_mismatch)
`ifdef EZLOGIC_CHECKER_CAPTURE_EN
      , .rd_addr(rd_addr), .rd_data(rd_data)
`endif
   );

   always #5 clk = ~clk;

   logic [7:0] exp_tbl [N] = '{
      8'h30, 8'h78, 8'h9d, 8'h56, 8'h92, 8'hf2, 8'hfe, 8'h23, 8'hbb, 8'h2c, 8'h5d, 8'h9e,
      8'h16, 8'h40, 8'h66, 8'h53, 8'hb6, 8'hcb, 8'h21, 8'h7c, 8'h95, 8'h29, 8'h98, 8'hce,
      8'h17, 8'hb7, 8'h14, 8'h37, 8'h88, 8'hd9, 8'h49, 8'h95, 8'h26, 8'h80, 8'hb4, 8'hbc,
      8'he4, 8'hc3, 8'h0a, 8'h96, 8'hc7, 8'h53};

   typedef struct {
      bit         busy, done, pass, timeout, overflow;
      int         byte_cnt, mis, first;
      logic [7:0] rd;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: the frame is just the list of accepted bytes plus a few flags.
   logic [7:0] got[$];
   int         idle = 0;
   bit         tmo  = 1'b0;
   bit         ovf  = 1'b0;
   logic [7:0] cap [N];

   task automatic model_step(input bit r, input bit c, input bit v, input logic [7:0] d,
                             input int ra, output exp_t e);
      e.rd = (ra < N) ? cap[ra] : 8'h00;
      if (r || c) begin
         got.delete();
         idle = 0; tmo = 1'b0; ovf = 1'b0;
         foreach (cap[i]) cap[i] = 8'h00;
         e.rd = 8'h00;
      end else if (tmo) begin
      end else if (got.size() == N) begin
         if (v) ovf = 1'b1;
      end else if (v) begin
         cap[got.size()] = d;
         got.push_back(d);
         idle = 0;
      end else if (got.size() > 0) begin
         idle++;
         if (idle >= TIMEOUT) tmo = 1'b1;
      end
      e.byte_cnt = got.size();
      e.mis      = 0;
      e.first    = N;
      foreach (got[i]) if (got[i] != exp_tbl[i]) begin
         e.mis++;
         if (e.first == N) e.first = i;
      end
      e.done     = (got.size() == N) || tmo;
      e.busy     = (got.size() > 0) && !e.done;
      e.timeout  = tmo;
      e.overflow = ovf;
      e.pass     = e.done && (e.mis == 0) && !ovf && !tmo;
   endtask

   // Called just after a falling edge; returns at the next falling edge.
   task automatic tick(input bit r, input bit c, input bit v, input logic [7:0] d, input int ra);
      exp_t e;
      int   a;
      a = (ra < 0) ? int'($urandom_range(0, 63)) : ra;
      rst = r; clear = c; valid_in = v; data_in = d;
`ifdef EZLOGIC_CHECKER_CAPTURE_EN
      rd_addr = CW'(a);
`endif
      model_step(r, c, v, d, a, e);
      @(posedge clk);
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (busy !== e.busy || done !== e.done || pass !== e.pass || timeout !== e.timeout ||
             overflow !== e.overflow || int'(byte_cnt) != e.byte_cnt ||
             int'(mismatch_cnt) != e.mis || int'(first_mismatch) != e.first) begin
            errors++;
            $display("FAIL status t=%0t got busy=%b done=%b pass=%b tmo=%b ovf=%b cnt=%0d mis=%0d first=%0d expected busy=%b done=%b pass=%b tmo=%b ovf=%b cnt=%0d mis=%0d first=%0d",
                     $time, busy, done, pass, timeout, overflow, byte_cnt, mismatch_cnt, first_mismatch,
                     e.busy, e.done, e.pass, e.timeout, e.overflow, e.byte_cnt, e.mis, e.first);
         end
`ifdef EZLOGIC_CHECKER_CAPTURE_EN
         checks++;
         if (rd_data !== e.rd) begin
            errors++;
            $display("FAIL rd_data t=%0t got %h expected %h", $time, rd_data, e.rd);
         end
`endif
      end
   end

   initial begin
      logic [7:0] d;
      bit         r;
      int         abort_at, stall_at, stall_len;
      rst = 1'b1; clear = 1'b0; valid_in = 1'b0; data_in = 8'h00;
`ifdef EZLOGIC_CHECKER_CAPTURE_EN
      rd_addr = '0;
`endif
      @(negedge clk);
      tick(1, 0, 0, 8'h00, -1);
      tick(1, 0, 1, 8'h30, -1);

      // clean back-to-back frame, capture readback, then one overflow byte
      for (int k = 0; k < N; k++) tick(0, 0, 1, exp_tbl[k], -1);
      tick(0, 0, 0, 8'h00, 0);
      tick(0, 0, 0, 8'h00, 41);
      tick(0, 0, 0, 8'h00, 50);
      tick(0, 0, 1, 8'h00, -1);
      repeat (3) tick(0, 0, 0, 8'h00, -1);
      tick(0, 1, 0, 8'h00, -1);

      // two corrupted bytes
      for (int k = 0; k < N; k++) begin
         d = exp_tbl[k];
         if (k == 1)  d = 8'h79;
         if (k == 10) d = exp_tbl[k] ^ 8'h5a;
         tick(0, 0, 1, d, -1);
      end
      repeat (2) tick(0, 0, 0, 8'h00, -1);
      tick(0, 1, 0, 8'h00, -1);

      // stall timeout after 20 bytes; late byte must be ignored
      for (int k = 0; k < 20; k++) tick(0, 0, 1, exp_tbl[k], -1);
      repeat (TIMEOUT + 3) tick(0, 0, 0, 8'h00, -1);
      tick(0, 0, 1, exp_tbl[20], -1);
      tick(0, 1, 0, 8'h00, -1);

      // clear coincident with a byte, then a good frame
      for (int k = 0; k < 5; k++) tick(0, 0, 1, exp_tbl[k], -1);
      tick(0, 1, 1, exp_tbl[5], -1);
      for (int k = 0; k < N; k++) tick(0, 0, 1, exp_tbl[k], -1);
      repeat (2) tick(0, 0, 0, 8'h00, -1);

      // reset mid-frame, then a good frame
      tick(0, 1, 0, 8'h00, -1);
      for (int k = 0; k < 7; k++) tick(0, 0, 1, exp_tbl[k], -1);
      tick(1, 0, 0, 8'h00, -1);
      for (int k = 0; k < N; k++) tick(0, 0, 1, exp_tbl[k], -1);
      tick(0, 1, 0, 8'h00, -1);

      // randomized frames: gaps, near/at-timeout stalls, corruption, aborts, trailing bytes
      for (int f = 0; f < 14; f++) begin
         abort_at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N-1)) : -1;
         stall_at  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, N-1)) : -1;
         stall_len = TIMEOUT - 1 + int'($urandom_range(0, 1));
         for (int k = 0; k < N; k++) begin
            if (k == abort_at) begin
               r = 1'($urandom_range(0, 1));
               tick(r, !r, 1'($urandom_range(0, 1)), exp_tbl[k], -1);
            end
            if (k == stall_at) repeat (stall_len) tick(0, 0, 0, 8'h00, -1);
            else if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick(0, 0, 0, 8'h00, -1);
            d = exp_tbl[k];
            if ($urandom_range(0, 15) == 0) d = d ^ 8'($urandom_range(1, 255));
            tick(0, 0, 1, d, -1);
         end
         repeat (3) tick(0, 0, 1'($urandom_range(0, 1)), 8'($urandom), -1);
         tick(0, 1, 0, 8'h00, -1);
      end

      tick(1, 0, 0, 8'h00, -1);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
